// File: rtl/led_axil_regs_if.sv
// AXI4-Lite bus bundle between the PS/VIP master and the LED register block.
// Carries the five AXI4-Lite channels: AW, W, B, AR, R (clock/reset are separate).
// slave modport is used by led_axil_regs; master modport by whatever drives it.
interface led_axil_regs_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID,    output WREADY,
    output BRESP, BVALID,           input  BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID,    input  RREADY
  );

  modport master (
    output AWADDR, AWPROT, AWVALID, input  AWREADY,
    output WDATA, WSTRB, WVALID,    input  WREADY,
    input  BRESP, BVALID,           output BREADY,
    output ARADDR, ARPROT, ARVALID, input  ARREADY,
    input  RDATA, RRESP, RVALID,    output RREADY
  );
endinterface

// File: rtl/led_axil_regs.sv
// AXI4-Lite slave holding LED_VAL/MODE/BLINK_DIV/SCRATCH and driving LED with optional blink.
// Latency: write commits on the edge both AW and W are present, BVALID next cycle; read RVALID one cycle after AR.
// Backpressure: one write and one read outstanding; AW/W stall while BVALID, AR stalls while RVALID.
// Ports: ACLK, ARESET (sync, active-high), s_axi (slave modport of led_axil_regs_if), LED.
module led_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int LED_WIDTH          = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  led_axil_regs_if.slave       s_axi,
  output logic [LED_WIDTH-1:0] LED
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  logic [DW-1:0] regs_q [0:3];
  logic [DW-1:0] regs_d [0:3];
  logic          aw_held_q, aw_held_d;
  logic [1:0]    aw_addr_q, aw_addr_d;
  logic          w_held_q, w_held_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [SW-1:0] w_strb_q, w_strb_d;
  logic          bvalid_q, bvalid_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [LED_WIDTH-1:0] led_q, led_d;

  logic          aw_rdy, w_rdy, ar_rdy;
  logic          aw_hs, w_hs, ar_hs, commit;
  logic [1:0]    wr_idx;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          blink_en;
  logic [LED_WIDTH-1:0] led_val;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

  assign aw_rdy = ~aw_held_q & ~bvalid_q;
  assign w_rdy  = ~w_held_q & ~bvalid_q;
  assign ar_rdy = ~rvalid_q;

  assign s_axi.AWREADY = aw_rdy;
  assign s_axi.WREADY  = w_rdy;
  assign s_axi.BRESP   = 2'b00;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.ARREADY = ar_rdy;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = 2'b00;
  assign s_axi.RVALID  = rvalid_q;
  assign LED           = led_q;

  always_comb begin
    regs_d    = regs_q;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;

    aw_hs = s_axi.AWVALID & aw_rdy;
    w_hs  = s_axi.WVALID & w_rdy;
    ar_hs = s_axi.ARVALID & ar_rdy;

    // Either half may come from the holding register or straight off the bus.
    wr_idx  = aw_held_q ? aw_addr_q : s_axi.AWADDR[3:2];
    wr_data = w_held_q  ? w_data_q  : s_axi.WDATA;
    wr_strb = w_held_q  ? w_strb_q  : s_axi.WSTRB;
    commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;

    if (commit) begin
      for (int b = 0; b < SW; b++) begin
        if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
      end
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_addr_d = s_axi.AWADDR[3:2];
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = s_axi.WDATA;
        w_strb_d = s_axi.WSTRB;
      end
      if (bvalid_q && s_axi.BREADY) bvalid_d = 1'b0;
    end

    // Read samples regs_q, so a same-edge write to the same register is not visible.
    if (ar_hs) begin
      rdata_d  = regs_q[s_axi.ARADDR[3:2]];
      rvalid_d = 1'b1;
    end else if (rvalid_q && s_axi.RREADY) begin
      rvalid_d = 1'b0;
    end

    // A BLINK_DIV written below cnt lets cnt run through the 32-bit wrap.
    blink_en = regs_q[1][0];
    led_val  = regs_q[0][LED_WIDTH-1:0];
    if (!blink_en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == regs_q[2][31:0]) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
    led_d = blink_en ? (phase_q ? led_val : '0) : led_val;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs_q    <= '{default: '0};
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      led_q     <= '0;
    end else begin
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      led_q     <= led_d;
    end
  end

endmodule

// File: doc/led_axil_regs.md
Name: led_axil_regs

Overview:
- AXI4-Lite slave (responder) holding the LED IP's four 32-bit registers.
- Drives the board LED outputs, with an optional blink mode.
- Sits behind the PS/VIP AXI4-Lite master; it answers the single-beat write/read traffic that the master issues.
- One outstanding write and one outstanding read at a time; all responses are OKAY.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decode uses ADDR[3:2].
- LED_WIDTH, 4, number of LED outputs; 1..32.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- AWPROT  in  3  ignored.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response; always 2'b00.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- ARPROT  in  3  ignored.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response; always 2'b00.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- LED  out  LED_WIDTH  LED drive.

Behaviour:
- Register map (all fully read/write, all reset to 0):
  - 0x0 LED_VAL
  - 0x4 MODE (bit0 = blink_en; the other bits are stored but have no effect)
  - 0x8 BLINK_DIV
  - 0xC SCRATCH
- ADDR[1:0] and PROT are ignored.
- Reset (synchronous, ARESET=1 at an edge):
  - All registers, aw_held, w_held, BVALID, RVALID, RDATA, blink counter and blink phase clear to 0.
  - LED = 0.
  - Any in-flight transaction is dropped.
  - AWREADY, WREADY and ARREADY read 1 the cycle after reset deasserts.
- Write channel:
  - AWREADY = ~aw_held & ~BVALID.
  - WREADY = ~w_held & ~BVALID.
  - An AW handshake with no W available latches the address (aw_held=1). A W handshake with no AW available latches WDATA/WSTRB (w_held=1). AW and W may arrive in either order or in the same cycle.
  - Commit edge: the first edge where both the address and the data are available (held or handshaking this cycle) and BVALID=0.
  - At commit: the selected register updates per byte where WSTRB[i]=1; held flags clear; BVALID=1 from the next cycle.
  - Latency: AW and W together at edge N gives the register update and BVALID high after edge N.
  - BVALID stays high until an edge with BREADY=1, then clears.
  - A new AW/W is not accepted while BVALID=1.
- Read channel:
  - ARREADY = ~RVALID.
  - On an AR handshake at edge N, RDATA is loaded with the addressed register value as it was before edge N, and RVALID=1 after edge N.
  - RDATA/RVALID hold until an edge with RREADY=1; RVALID then clears and RDATA keeps its value.
  - A read and a write to the same register committing on the same edge: the read returns the old value.
  - Read and write channels are independent and may be concurrent.
- Blink logic (32-bit counter cnt, 1-bit phase):
  - blink_en=0: cnt=0, phase=0, LED = LED_VAL[LED_WIDTH-1:0].
  - blink_en=1: each cycle, if cnt==BLINK_DIV then cnt<=0 and phase<=~phase, else cnt<=cnt+1.
  - blink_en=1: LED = phase ? LED_VAL[LED_WIDTH-1:0] : 0.
  - Period = 2*(BLINK_DIV+1) cycles. BLINK_DIV=0 toggles phase every cycle.
  - If BLINK_DIV is written below the current cnt, cnt counts up to 2^32-1, wraps to 0, and proceeds normally; no special handling.
  - Clearing blink_en returns cnt and phase to 0 on the next edge.
- LED is registered: it reflects register/phase state one cycle after that state changes.

Test Plan:
- Reset, then write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC (WSTRB=0xF, AW+W same cycle), then read back the four addresses -> reads return 0x1, 0x2, 0x3, 0x4; every BRESP/RRESP=0; BVALID rises 1 cycle after each handshake; LED=4'h1 (MODE bit0=0).
- AW at cycle 0, W at cycle 3 on 0xC with data 0xDEADBEEF; repeat with W first and AW 3 cycles later -> one BVALID per write, after the later handshake; both reads of 0xC = 0xDEADBEEF.
- Write 0x11223344 to 0xC, then write 0xAABBCCDD with WSTRB=4'b0101 -> read of 0xC = 0x11BB33DD.
- Hold BREADY=0 for 5 cycles after a write -> BVALID stays 1; AWREADY=WREADY=0; a second AWVALID is not accepted until after the BREADY edge. Repeat with RREADY=0 on the read channel -> RDATA stable and ARREADY=0.
- LED_VAL=0xF, BLINK_DIV=2, MODE=1 -> LED alternates 0x0/0xF, each level held 3 cycles (6-cycle period); then write MODE=0 -> LED=0xF steady and the counter clears.
- Assert ARESET mid-write (AW held, W not yet sent) and mid-read with RVALID=1 -> next cycle all registers read 0, BVALID=RVALID=0, LED=0, and no response is issued for the dropped transactions.
